// File: rtl/occupancy_balance_monitor_pkg.sv
// Shared types and helpers for the occupancy balance monitor.
package occupancy_balance_monitor_pkg;

    // Alarm FSM state encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ALARM   = 2'd2,
        ACKED   = 2'd3
    } state_e;

    // Ceiling log2 with a floor of 1, so every index or counter is at least one bit wide.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/occupancy_balance_monitor_minmax_reduce.sv
// Combinational N-way max/min over packed room counts; ties resolve to the lowest index.
module minmax_reduce
    import occupancy_balance_monitor_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int W  = 3,
    localparam int IW = clog2(N)
) (
    input  logic [N*W-1:0] counts,
    output logic [W-1:0]   max_val,
    output logic [W-1:0]   min_val,
    output logic [IW-1:0]  max_idx,
    output logic [IW-1:0]  min_idx
);

    // Linear scan; strict comparisons keep the earliest room on ties.
    always_comb begin
        max_val = counts[0 +: W];
        min_val = counts[0 +: W];
        max_idx = '0;
        min_idx = '0;
        for (int i = 1; i < N; i++) begin
            if (counts[i*W +: W] > max_val) begin
                max_val = counts[i*W +: W];
                max_idx = IW'(i);
            end
            if (counts[i*W +: W] < min_val) begin
                min_val = counts[i*W +: W];
                min_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/occupancy_balance_monitor.sv
// Occupancy balance monitor: registers the max/min spread across N rooms and raises a
// debounced, latched, acknowledgeable alarm when the spread stays above TOL for HOLD cycles.
module occupancy_balance_monitor
    import occupancy_balance_monitor_pkg::*;
#(
    parameter  int N    = 3,
    parameter  int W    = 3,
    parameter  int TOL  = 1,
    parameter  int HOLD = 4,
    parameter  int CW   = 8,
    localparam int IW   = clog2(N)
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           enable,
    input  logic [N*W-1:0] counts,
    input  logic           ack,
    output logic           alarm,
    output logic           pending,
    output logic [W-1:0]   spread,
    output logic [IW-1:0]  max_idx,
    output logic [IW-1:0]  min_idx,
    output logic [CW-1:0]  alarm_count
);

    // Persistence counter only needs to reach HOLD-1, so it never wraps.
    localparam int                CNT_W     = clog2(HOLD + 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD - 1);

    logic [W-1:0]  max_val;
    logic [W-1:0]  min_val;
    logic [IW-1:0] max_idx_c;
    logic [IW-1:0] min_idx_c;

    logic [W-1:0]  spread_d,  spread_q;
    logic [IW-1:0] max_idx_d, max_idx_q;
    logic [IW-1:0] min_idx_d, min_idx_q;
    logic          imb_d,     imb_q;

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;
    logic             alarm_d, alarm_q;
    logic             pending_d, pending_q;
    logic [CW-1:0]    alarm_count_d, alarm_count_q;
    logic             enter_alarm;

    minmax_reduce #(
        .N (N),
        .W (W)
    ) u_minmax (
        .counts  (counts),
        .max_val (max_val),
        .min_val (min_val),
        .max_idx (max_idx_c),
        .min_idx (min_idx_c)
    );

    // Stage-1 next values: spread is max minus min, so it cannot underflow.
    always_comb begin
        spread_d  = max_val - min_val;
        max_idx_d = max_idx_c;
        min_idx_d = min_idx_c;
        imb_d     = int'(spread_d) > TOL;
    end

    // Stage-1 register: spread, indices and imbalance flag share one cycle of latency.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state is written with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            spread_q  <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            imb_q     <= 1'b0;
        end else begin
            spread_q  <= spread_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            imb_q     <= imb_d;
        end
    end

    // Alarm FSM next-state, persistence count, and registered output decode.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        enter_alarm   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable && imb_q) begin
                    if (HOLD == 1) begin
                        state_d     = ALARM;
                        enter_alarm = 1'b1;
                    end else begin
                        state_d = PENDING;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            PENDING: begin
                if (!imb_q || !enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    // An ack landing on this cycle is deliberately ignored.
                    state_d     = ALARM;
                    cnt_d       = '0;
                    enter_alarm = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ALARM: begin
                cnt_d = '0;
                if (ack) begin
                    state_d = imb_q ? ACKED : IDLE;
                end
            end
            ACKED: begin
                // Stay silent until the imbalance clears; no re-alarm on the same event.
                cnt_d = '0;
                if (!imb_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        alarm_d   = (state_d == ALARM);
        pending_d = (state_d == PENDING);

        alarm_count_d = alarm_count_q;
        if (enter_alarm && (alarm_count_q != {CW{1'b1}})) begin
            alarm_count_d = alarm_count_q + CW'(1);
        end
    end

    // FSM and output registers; reset clears the alarm without waiting for a clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            alarm_q       <= 1'b0;
            pending_q     <= 1'b0;
            alarm_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alarm_q       <= alarm_d;
            pending_q     <= pending_d;
            alarm_count_q <= alarm_count_d;
        end
    end

    assign alarm       = alarm_q;
    assign pending     = pending_q;
    assign spread      = spread_q;
    assign max_idx     = max_idx_q;
    assign min_idx     = min_idx_q;
    assign alarm_count = alarm_count_q;

endmodule

// File: tb/tb_occupancy_balance_monitor.sv
// Directed bench for occupancy_balance_monitor: default instance plus a HOLD=1, CW=2
// instance used for alarm counter saturation.
module tb_occupancy_balance_monitor;

    logic       clock;
    logic       reset_n;

    logic       enable;
    logic [8:0] counts;
    logic       ack;
    logic       alarm;
    logic       pending;
    logic [2:0] spread;
    logic [1:0] max_idx;
    logic [1:0] min_idx;
    logic [7:0] alarm_count;

    logic       s_enable;
    logic [8:0] s_counts;
    logic       s_ack;
    logic       s_alarm;
    logic       s_pending;
    logic [2:0] s_spread;
    logic [1:0] s_max_idx;
    logic [1:0] s_min_idx;
    logic [1:0] s_alarm_count;

    int total = 0;
    int bad   = 0;

    occupancy_balance_monitor #(
        .N    (3),
        .W    (3),
        .TOL  (1),
        .HOLD (4),
        .CW   (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .counts      (counts),
        .ack         (ack),
        .alarm       (alarm),
        .pending     (pending),
        .spread      (spread),
        .max_idx     (max_idx),
        .min_idx     (min_idx),
        .alarm_count (alarm_count)
    );

    occupancy_balance_monitor #(
        .N    (3),
        .W    (3),
        .TOL  (1),
        .HOLD (1),
        .CW   (2)
    ) dut_sat (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (s_enable),
        .counts      (s_counts),
        .ack         (s_ack),
        .alarm       (s_alarm),
        .pending     (s_pending),
        .spread      (s_spread),
        .max_idx     (s_max_idx),
        .min_idx     (s_min_idx),
        .alarm_count (s_alarm_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Room 0 in the low bits.
    function automatic logic [8:0] pack3(input int c0, input int c1, input int c2);
        return {3'(c2), 3'(c1), 3'(c0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        ack      = 1'b0;
        counts   = pack3(2, 2, 2);
        s_enable = 1'b0;
        s_ack    = 1'b0;
        s_counts = pack3(0, 0, 0);

        // Reset state
        tick();
        check("rst_alarm",   32'(alarm),       0);
        check("rst_pending", 32'(pending),     0);
        check("rst_spread",  32'(spread),      0);
        check("rst_max_idx", 32'(max_idx),     0);
        check("rst_min_idx", 32'(min_idx),     0);
        check("rst_count",   32'(alarm_count), 0);
        check("rst_s_count", 32'(s_alarm_count), 0);

        // Balanced after release
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();
        check("bal_spread",  32'(spread),  0);
        check("bal_pending", 32'(pending), 0);
        check("bal_alarm",   32'(alarm),   0);

        // Persistence: {3,1,2}
        counts = pack3(3, 1, 2);
        tick();
        check("p_spread",  32'(spread),  2);
        check("p_max_idx", 32'(max_idx), 0);
        check("p_min_idx", 32'(min_idx), 1);
        check("p_pend_k",  32'(pending), 0);
        tick();
        check("p_pend_k1", 32'(pending), 1);
        tick();
        check("p_pend_k2", 32'(pending), 1);
        tick();
        check("p_pend_k3", 32'(pending), 1);
        check("p_alarm_k3", 32'(alarm),  0);
        tick();
        check("p_alarm_k4", 32'(alarm),  1);
        check("p_pend_k4",  32'(pending), 0);
        check("p_count",    32'(alarm_count), 1);

        // Ack while imbalanced -> ACKED, no re-alarm
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_alarm", 32'(alarm),   0);
        check("ack_pend",  32'(pending), 0);
        tick(3);
        check("acked_alarm", 32'(alarm),       0);
        check("acked_pend",  32'(pending),     0);
        check("acked_count", 32'(alarm_count), 1);

        // Balance -> IDLE, then a new imbalance re-alarms
        counts = pack3(2, 2, 2);
        tick(2);
        check("ack_bal_alarm", 32'(alarm), 0);
        counts = pack3(3, 1, 2);
        tick(2);
        check("realarm_pend", 32'(pending), 1);
        tick(3);
        check("realarm_alarm", 32'(alarm),       1);
        check("realarm_count", 32'(alarm_count), 2);

        // Alarm held while balanced; ack with no imbalance -> IDLE
        counts = pack3(2, 2, 2);
        tick();
        check("held_bal_alarm", 32'(alarm), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_idle_alarm", 32'(alarm), 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("idle_ack_alarm", 32'(alarm),   0);
        check("idle_ack_pend",  32'(pending), 0);

        // Glitch rejection: 3 imbalanced samples, 1 balanced, then imbalanced
        counts = pack3(3, 1, 2);
        tick(2);
        check("g_pend_e2", 32'(pending), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("g_pend_ack", 32'(pending), 1);
        check("g_alarm_ack", 32'(alarm),  0);
        counts = pack3(2, 1, 2);
        tick();
        check("g_pend_e4", 32'(pending), 1);
        check("g_spread",  32'(spread),  1);
        counts = pack3(3, 1, 2);
        tick();
        check("g_pend_e5", 32'(pending), 0);
        check("g_alarm_e5", 32'(alarm),  0);
        tick();
        check("g_pend_e6", 32'(pending), 1);
        tick(2);
        check("g_pend_e8",  32'(pending), 1);
        check("g_alarm_e8", 32'(alarm),   0);
        tick();
        check("g_alarm_e9", 32'(alarm),       1);
        check("g_count",    32'(alarm_count), 3);

        // enable low in ALARM: alarm held
        enable = 1'b0;
        tick(2);
        check("en_alarm_held", 32'(alarm), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("en_ack_alarm", 32'(alarm), 0);
        tick(2);
        check("en_acked_alarm", 32'(alarm),   0);
        check("en_acked_pend",  32'(pending), 0);
        counts = pack3(2, 2, 2);
        tick(2);

        // enable low in PENDING -> IDLE
        enable = 1'b1;
        counts = pack3(3, 1, 2);
        tick(2);
        check("enp_pend", 32'(pending), 1);
        enable = 1'b0;
        tick();
        check("enp_off_pend", 32'(pending), 0);
        tick();
        check("enp_off_pend2",  32'(pending), 0);
        check("enp_off_alarm",  32'(alarm),   0);
        enable = 1'b1;
        tick();
        check("enp_on_pend", 32'(pending), 1);
        tick(2);
        check("enp_pend_last", 32'(pending), 1);

        // Ack on the PENDING->ALARM cycle: alarm still raised, ack not carried
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ackpend_alarm", 32'(alarm),       1);
        check("ackpend_count", 32'(alarm_count), 4);
        tick();
        check("ackpend_held", 32'(alarm), 1);

        // Tie and tolerance boundary
        counts = pack3(1, 0, 1);
        tick();
        check("tie_spread",  32'(spread),  1);
        check("tie_max_idx", 32'(max_idx), 0);
        check("tie_min_idx", 32'(min_idx), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("tie_ack_alarm", 32'(alarm), 0);
        tick(2);
        check("tol_pend", 32'(pending), 0);
        counts = pack3(4, 4, 0);
        tick();
        check("tie2_max_idx", 32'(max_idx), 0);
        check("tie2_min_idx", 32'(min_idx), 2);
        check("tie2_spread",  32'(spread),  4);
        tick(4);
        check("tie2_alarm", 32'(alarm),       1);
        check("tie2_count", 32'(alarm_count), 5);

        // Asynchronous reset mid-ALARM
        reset_n = 1'b0;
        #1;
        check("arst_alarm",   32'(alarm),       0);
        check("arst_count",   32'(alarm_count), 0);
        check("arst_pending", 32'(pending),     0);
        check("arst_spread",  32'(spread),      0);
        counts = pack3(2, 2, 2);
        tick();
        reset_n = 1'b1;
        tick();
        check("rel_spread",  32'(spread),  0);
        check("rel_pending", 32'(pending), 0);
        check("rel_alarm",   32'(alarm),   0);

        // Saturation: HOLD=1, CW=2, five alarm entries
        s_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_counts = pack3(3, 0, 0);
            tick(2);
            check("sat_alarm", 32'(s_alarm), 1);
            check("sat_count", 32'(s_alarm_count), (i + 1 > 3) ? 3 : i + 1);
            s_counts = pack3(0, 0, 0);
            s_ack    = 1'b1;
            tick();
            s_ack = 1'b0;
            check("sat_ack_alarm", 32'(s_alarm), 0);
            tick();
        end
        check("sat_final", 32'(s_alarm_count), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
